// File: rtl/sync_fifo_pkg.sv
// Shared definitions for the synchronous FIFO output stage.
//   state_e   : output-buffer fill state (EMPTY / ONE / TWO entries held)
//   OccW      : width of the occupancy count (values 0..2)
//   state_occ : maps a buffer state to its occupancy count
package sync_fifo_pkg;

  localparam int unsigned OccW = 2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  function automatic logic [OccW-1:0] state_occ(state_e s);
    logic [OccW-1:0] occ;
    occ = '0;
    case (s)
      ONE:     occ = 2'd1;
      TWO:     occ = 2'd2;
      default: occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/sync_fifo_skid_reg.sv
// Data register with load enable, used for the head and skid slots of the
// FIFO output stage.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset, clears q to 0
//   en    : load enable
//   d     : data in
//   q     : registered data out
module sync_fifo_skid_reg #(
  parameter int unsigned width = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [width-1:0] d,
  output logic [width-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/sync_fifo_out_stage.sv
// Two-entry output buffer between a FIFO read-pointer stage and a
// valid/ready consumer. Holds a head entry (presented downstream) and a skid
// entry, so ren never depends combinationally on send_rdy while still
// sustaining one transfer per cycle.
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   fifo_empty : FIFO has no readable entry
//   fifo_rdata : FIFO word at the read pointer
//   ren        : consume request to the FIFO
//   flush      : synchronous discard of buffered entries
//   send_val   : downstream valid (registered)
//   send_msg   : downstream data, head entry (registered)
//   send_rdy   : downstream ready
//   occupancy  : entries held, 0..2 (registered)
module sync_fifo_out_stage
  import sync_fifo_pkg::*;
#(
  parameter int unsigned width = 32,
  parameter int unsigned depth = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fifo_empty,
  input  logic [width-1:0] fifo_rdata,
  output logic             ren,
  input  logic             flush,
  output logic             send_val,
  output logic [width-1:0] send_msg,
  input  logic             send_rdy,
  output logic [OccW-1:0]  occupancy
);

  if (depth < 1) begin : g_bad_depth
    $error("sync_fifo_out_stage: depth must be at least 1");
  end

  state_e            state_q, state_d;
  logic              val_q;
  logic [OccW-1:0]   occ_q;
  logic              load, send;
  logic              head_en, skid_en, head_from_skid;
  logic [width-1:0]  head_q, head_d, skid_q;

  // Gated by rst_n so the FIFO sees no consume while reset is held.
  assign ren  = rst_n & ~fifo_empty & (state_q != TWO) & ~flush;
  assign load = ren & ~fifo_empty;
  assign send = val_q & send_rdy;

  always_comb begin
    state_d        = state_q;
    head_en        = 1'b0;
    skid_en        = 1'b0;
    head_from_skid = 1'b0;
    if (flush) begin
      // A concurrent send has already completed downstream; just drop the rest.
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (load) begin
            state_d = ONE;
            head_en = 1'b1;
          end
        end
        ONE: begin
          if (load && send) begin
            head_en = 1'b1;
          end else if (load) begin
            state_d = TWO;
            skid_en = 1'b1;
          end else if (send) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (send) begin
            state_d        = ONE;
            head_en        = 1'b1;
            head_from_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  assign head_d = head_from_skid ? skid_q : fifo_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      val_q   <= 1'b0;
      occ_q   <= '0;
    end else begin
      state_q <= state_d;
      val_q   <= (state_d != EMPTY);
      occ_q   <= state_occ(state_d);
    end
  end

  sync_fifo_skid_reg #(
    .width (width)
  ) u_head (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (head_en),
    .d     (head_d),
    .q     (head_q)
  );

  sync_fifo_skid_reg #(
    .width (width)
  ) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (skid_en),
    .d     (fifo_rdata),
    .q     (skid_q)
  );

  assign send_val  = val_q;
  assign send_msg  = head_q;
  assign occupancy = occ_q;

endmodule

// File: tb/tb_sync_fifo_out_stage.sv
module tb_sync_fifo_out_stage;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         fifo_empty;
  logic [W-1:0] fifo_rdata;
  logic         ren;
  logic         flush;
  logic         send_val;
  logic [W-1:0] send_msg;
  logic         send_rdy;
  logic [1:0]   occupancy;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  logic [W-1:0] src_q[$];   // words the FIFO will supply
  logic [W-1:0] exp_q[$];   // words consumed but not yet delivered
  logic         force_empty;
  int unsigned  n_dlv;
  int unsigned  n_push;

  always #5 clk = ~clk;

  sync_fifo_out_stage #(
    .width (W),
    .depth (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fifo_empty (fifo_empty),
    .fifo_rdata (fifo_rdata),
    .ren        (ren),
    .flush      (flush),
    .send_val   (send_val),
    .send_msg   (send_msg),
    .send_rdy   (send_rdy),
    .occupancy  (occupancy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_fifo();
    fifo_empty = force_empty || (src_q.size() == 0);
    fifo_rdata = (src_q.size() != 0) ? src_q[0] : '0;
  endtask

  // Samples handshakes just before an edge, then updates the FIFO model and
  // scoreboard from what happened at that edge.
  task automatic tick();
    logic         cons, dlv, fl;
    logic [W-1:0] got;
    #1;
    cons = ren & ~fifo_empty;
    dlv  = send_val & send_rdy;
    fl   = flush;
    got  = send_msg;
    if (occupancy == 2'd2) check_eq("ren_in_two", {31'd0, ren}, 32'd0);
    @(posedge clk);
    #1;
    if (dlv) begin
      n_dlv++;
      if (exp_q.size() == 0) check_eq("spurious_send", 32'd1, 32'd0);
      else check_eq("order", {24'd0, got}, {24'd0, exp_q.pop_front()});
    end
    if (fl) exp_q.delete();
    if (cons) exp_q.push_back(src_q.pop_front());
    drive_fifo();
  endtask

  initial begin
    rst_n       = 1'b0;
    flush       = 1'b0;
    send_rdy    = 1'b0;
    force_empty = 1'b1;
    n_dlv       = 0;
    drive_fifo();
    #12;
    check_eq("rst_val", {31'd0, send_val}, 32'd0);
    check_eq("rst_msg", {24'd0, send_msg}, 32'd0);
    check_eq("rst_occ", {30'd0, occupancy}, 32'd0);
    check_eq("rst_ren", {31'd0, ren}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle with empty FIFO.
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("idle_ren", {31'd0, ren}, 32'd0);
      check_eq("idle_val", {31'd0, send_val}, 32'd0);
      check_eq("idle_occ", {30'd0, occupancy}, 32'd0);
    end

    // Streaming, one cycle latency, back-to-back.
    force_empty = 1'b0;
    send_rdy    = 1'b1;
    src_q.push_back(8'h11); src_q.push_back(8'h22); src_q.push_back(8'h33);
    drive_fifo();
    tick(); check_eq("stream_v0", {31'd0, send_val}, 32'd1);
    check_eq("stream_m0", {24'd0, send_msg}, 32'h11);
    tick(); check_eq("stream_m1", {24'd0, send_msg}, 32'h22);
    tick(); check_eq("stream_m2", {24'd0, send_msg}, 32'h33);
    check_eq("stream_occ", {30'd0, occupancy}, 32'd1);
    tick(); check_eq("stream_done", {31'd0, send_val}, 32'd0);

    // Backpressure fills both slots.
    send_rdy = 1'b0;
    src_q.push_back(8'h0A); src_q.push_back(8'h0B); src_q.push_back(8'h0C);
    drive_fifo();
    tick(); check_eq("bp_occ1", {30'd0, occupancy}, 32'd1);
    tick(); check_eq("bp_occ2", {30'd0, occupancy}, 32'd2);
    #1;
    check_eq("bp_ren_low", {31'd0, ren}, 32'd0);
    tick(); check_eq("bp_hold", {24'd0, send_msg}, 32'h0A);
    check_eq("bp_left", src_q.size(), 32'd1);
    send_rdy = 1'b1;
    tick(); check_eq("bp_m1", {24'd0, send_msg}, 32'h0B);
    tick(); check_eq("bp_m2", {24'd0, send_msg}, 32'h0C);
    tick(); check_eq("bp_done", {31'd0, send_val}, 32'd0);

    // Flush in TWO with a concurrent send.
    send_rdy = 1'b0;
    src_q.push_back(8'h5A); src_q.push_back(8'h5B);
    drive_fifo();
    tick(); tick();
    check_eq("fl_occ2", {30'd0, occupancy}, 32'd2);
    n_dlv    = 0;
    send_rdy = 1'b1;
    flush    = 1'b1;
    tick();
    flush = 1'b0;
    check_eq("fl_sent", n_dlv, 32'd1);
    check_eq("fl_occ0", {30'd0, occupancy}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("fl_no5b", {31'd0, send_val}, 32'd0);
    end

    // Asynchronous reset in ONE.
    send_rdy = 1'b0;
    src_q.push_back(8'h77);
    drive_fifo();
    tick();
    check_eq("ar_pre_msg", {24'd0, send_msg}, 32'h77);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("ar_val", {31'd0, send_val}, 32'd0);
    check_eq("ar_occ", {30'd0, occupancy}, 32'd0);
    check_eq("ar_msg", {24'd0, send_msg}, 32'd0);
    exp_q.delete();
    src_q.push_back(8'h88);
    drive_fifo();
    check_eq("ar_ren", {31'd0, ren}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n    = 1'b1;
    send_rdy = 1'b1;
    n_dlv    = 0;
    tick();
    check_eq("ar_first_v", {31'd0, send_val}, 32'd1);
    check_eq("ar_first_m", {24'd0, send_msg}, 32'h88);
    tick();
    check_eq("ar_dlv", n_dlv, 32'd1);

    // Random traffic.
    n_dlv  = 0;
    n_push = 0;
    for (int i = 0; i < 10000; i++) begin
      if (src_q.size() < 4 && $urandom_range(0, 1) == 1) begin
        src_q.push_back(W'(n_push));
        n_push++;
      end
      force_empty = ($urandom_range(0, 3) == 0);
      send_rdy    = ($urandom_range(0, 2) != 0);
      drive_fifo();
      tick();
    end
    force_empty = 1'b0;
    send_rdy    = 1'b1;
    drive_fifo();
    for (int i = 0; i < 50 && (src_q.size() != 0 || exp_q.size() != 0); i++) tick();
    check_eq("rnd_drained", exp_q.size() + src_q.size(), 32'd0);
    check_eq("rnd_lossless", n_dlv, n_push);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
